// File: rtl/lc3_pkg.sv
// Shared SLC-3 definitions: fetch FSM states, opcode map and reset defaults.
package lc3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    localparam logic [3:0] OP_BR   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_JSR  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_LDR  = 4'h6;
    localparam logic [3:0] OP_STR  = 4'h7;
    localparam logic [3:0] OP_RTI  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_STI  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RES  = 4'hD;
    localparam logic [3:0] OP_LEA  = 4'hE;
    localparam logic [3:0] OP_TRAP = 4'hF;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
    localparam int          TMO_W            = 8;

endpackage

// File: rtl/ir_field_decode.sv
// Pure combinational slicing of an SLC-3 instruction word into its raw fields.
module ir_field_decode (
    input  logic [15:0] i_ir,
    output logic [3:0]  o_opcode,
    output logic [2:0]  o_dr,
    output logic [2:0]  o_sr1,
    output logic [2:0]  o_sr2,
    output logic [4:0]  o_imm5_field,
    output logic [5:0]  o_offset6_field,
    output logic [8:0]  o_pcoffset9_field,
    output logic [10:0] o_pcoffset11_field
);

    assign o_opcode           = i_ir[15:12];
    assign o_dr               = i_ir[11:9];
    assign o_sr1              = i_ir[8:6];
    assign o_sr2              = i_ir[2:0];
    assign o_imm5_field       = i_ir[4:0];
    assign o_offset6_field    = i_ir[5:0];
    assign o_pcoffset9_field  = i_ir[8:0];
    assign o_pcoffset11_field = i_ir[10:0];

endmodule

// File: rtl/ir_fetch_unit.sv
// SLC-3 fetch sequencer: PC, IR, memory read handshake with timeout, and
// hold of each instruction until execute reports completion.
module ir_fetch_unit
    import lc3_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          MEM_TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_run,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_rd,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_ready,
    output logic [15:0] o_ir,
    output logic        o_ir_valid,
    input  logic        i_exec_done,
    input  logic        i_pc_load,
    input  logic [15:0] i_pc_in,
    output logic [15:0] o_pc_out,
    output logic        o_fault,
    output logic [3:0]  o_opcode,
    output logic [2:0]  o_dr,
    output logic [2:0]  o_sr1,
    output logic [2:0]  o_sr2,
    output logic [4:0]  o_imm5_field,
    output logic [5:0]  o_offset6_field,
    output logic [8:0]  o_pcoffset9_field,
    output logic [10:0] o_pcoffset11_field
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

    fetch_state_t     r_state, w_state_nxt;
    logic [15:0]      r_pc, r_ir, r_mem_addr;
    logic [TMO_W-1:0] r_count;
    logic [TMO_W-1:0] w_count_inc;

    assign w_count_inc = r_count + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_run) w_state_nxt = ST_ADDR;
            ST_ADDR:  w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (i_mem_ready)                 w_state_nxt = ST_ISSUE;
                else if (w_count_inc == TMO_LIMIT) w_state_nxt = ST_FAULT;
            end
            // run is sampled only at completion, so a dropped run still finishes the issue
            ST_ISSUE: if (i_exec_done) w_state_nxt = i_run ? ST_ADDR : ST_IDLE;
            ST_FAULT: w_state_nxt = ST_FAULT;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_mem_rd   = 1'b0;
        o_ir_valid = 1'b0;
        o_fault    = 1'b0;
        case (r_state)
            ST_WAIT:  o_mem_rd   = 1'b1;
            ST_ISSUE: o_ir_valid = 1'b1;
            ST_FAULT: o_fault    = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc       <= RESET_PC;
            r_ir       <= 16'h0000;
            r_mem_addr <= 16'h0000;
            r_count    <= '0;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    r_mem_addr <= r_pc;
                    r_pc       <= r_pc + 16'd1;
                    r_count    <= '0;
                end
                ST_WAIT: begin
                    if (i_mem_ready) r_ir    <= i_mem_rdata;
                    else             r_count <= w_count_inc;
                end
                ST_ISSUE: if (i_exec_done && i_pc_load) r_pc <= i_pc_in;
                default: ;
            endcase
        end
    end

    assign o_mem_addr = r_mem_addr;
    assign o_ir       = r_ir;
    assign o_pc_out   = r_pc;

    ir_field_decode u_decode (
        .i_ir               (r_ir),
        .o_opcode           (o_opcode),
        .o_dr               (o_dr),
        .o_sr1              (o_sr1),
        .o_sr2              (o_sr2),
        .o_imm5_field       (o_imm5_field),
        .o_offset6_field    (o_offset6_field),
        .o_pcoffset9_field  (o_pcoffset9_field),
        .o_pcoffset11_field (o_pcoffset11_field)
    );

endmodule
